edge_capture_stage: RTL
=======================

Name: edge_capture_stage

Overview:
- Upstream stage for an edge-clocked sampling register.
- Synchronises an asynchronous event line into the `clk` domain and detects the selected edge on it.
- On each detected edge, captures the data word present at that moment into a small FIFO.
- The downstream consumer drains the FIFO through a valid/ready handshake; an overflow is reported and never silently absorbed.

Parameters:
- DATA_W, 8, width of captured data word
- DEPTH, 4, FIFO entries; power of two, minimum 2
- SYNC_STAGES, 2, synchroniser flops on `evt_i`; minimum 2
- TS_W, 16, timestamp width; used only with EDGE_TIMESTAMP_EN

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- evt_i  in  1  asynchronous event line
- data_i  in  DATA_W  word sampled on a detected edge; must be stable for SYNC_STAGES+1 cycles around `evt_i` transitions
- mode_i  in  2  edge select, edge_mode_e: 0 = posedge, 1 = negedge, 2 = both, 3 = disabled
- out_valid_o  out  1  FIFO head is valid
- out_data_o  out  DATA_W  FIFO head data
- out_ready_i  in  1  consumer accepts the head
- overflow_o  out  1  sticky: an edge was dropped because the FIFO was full
- clr_ovf_i  in  1  synchronous clear of `overflow_o`
- count_o  out  $clog2(DEPTH)+1  current occupancy
- out_ts_o  out  TS_W  FIFO head timestamp; present only with EDGE_TIMESTAMP_EN

Behaviour:
- Reset (asynchronous on `rst_n` low):
  - synchroniser flops and previous-sample flop = 0
  - FIFO pointers = 0, `count_o` = 0
  - `out_valid_o` = 0, `out_data_o` = 0, `overflow_o` = 0
  - `out_ts_o` = 0 and timestamp counter = 0
- Reset deassertion: a first synchronised value of 1 after reset is not a posedge, because the previous-sample flop is loaded from the synchroniser output for one cycle before edge detection is armed (`armed` flag).
- Edge detect:
  - `rise` = sync & ~prev; `fall` = ~sync & prev
  - `hit` = rise (mode 0), fall (mode 1), rise|fall (mode 2), 0 (mode 3)
  - Evaluated combinationally from registered values.
  - Latency from an `evt_i` transition to `out_valid_o` is SYNC_STAGES+1 cycles when the FIFO is empty.
- Data capture: `data_i` is registered alongside the last synchroniser stage, so the captured word is aligned with the detected edge.
- Push: occurs on `hit` when `count` < DEPTH, or when `count` == DEPTH and a pop happens in the same cycle (push-through-full is allowed).
- Pop: occurs when `out_valid_o` && `out_ready_i`.
  - `out_data_o` is held stable while `out_valid_o` && !`out_ready_i`.
  - `out_valid_o` never deasserts without a pop.
- Occupancy:
  - Simultaneous push and pop leaves `count` unchanged.
  - Pointers wrap modulo DEPTH; `count` has an extra bit to distinguish full from empty.
- Overflow:
  - `hit` while full with no pop: the word is dropped and `overflow_o` is set the next cycle.
  - `overflow_o` stays set until `clr_ovf_i`.
  - Set takes priority over a same-cycle clear.
- Empty FIFO with simultaneous push: `out_valid_o` rises the following cycle; there is no bypass path.
- `mode_i` change takes effect the next cycle. It does not generate a spurious edge, because `prev` is always updated.
- Reset mid-operation flushes the FIFO and clears the overflow flag immediately.

Optional Feature:
- Macro: EDGE_TIMESTAMP_EN
- Defined:
  - A free-running TS_W counter increments every cycle and wraps at 2^TS_W.
  - Its value at the push cycle is stored with each entry and presented on `out_ts_o` with `out_data_o`.
- Undefined:
  - No counter, no timestamp storage.
  - `out_ts_o` port is absent.

Decomposition:
- Package edge_capture_pkg:
  - typedef enum logic [1:0] edge_mode_e {EDGE_POS, EDGE_NEG, EDGE_BOTH, EDGE_OFF}
  - function clog2-based count-width helper
- Sub-module sync_chain (parameter SYNC_STAGES; ports clk, rst_n, d, q): the multi-flop synchroniser, reset to 0.
- FIFO storage and control stay in the top module.

Test Plan:
- Posedge capture: mode 0, data_i = 8'hA5, evt_i 0→1 → out_valid_o high 3 cycles later, out_data_o = 8'hA5, count_o = 1; evt_i 1→0 produces nothing.
- Both edges: mode 2, toggle evt_i 4 times with data 1, 2, 3, 4 while out_ready_i = 0 → count_o = 4; drain returns 1, 2, 3, 4 in order.
- Overflow: DEPTH 4 full, out_ready_i = 0, one more edge → overflow_o = 1, count_o stays 4, entry dropped; clr_ovf_i pulse → overflow_o = 0.
- Push-through-full: full FIFO, out_ready_i = 1 on the same cycle as hit → no overflow, count_o stays 4, new word appears last.
- Reset mid-stream: 3 entries queued, assert rst_n low asynchronously → out_valid_o = 0 and count_o = 0 without a clock edge; evt_i held 1 through release → no capture.
- With EDGE_TIMESTAMP_EN, TS_W = 4: edges at counter values 14 and 1 (after wrap) → out_ts_o = 14 then 1.

Source files
------------

// File: rtl/edge_capture_pkg.sv
// Shared types and helpers for the edge capture stage.
// Holds the edge-select encoding and the occupancy width helper.
package edge_capture_pkg;

    typedef enum logic [1:0] {
        EDGE_POS  = 2'd0,
        EDGE_NEG  = 2'd1,
        EDGE_BOTH = 2'd2,
        EDGE_OFF  = 2'd3
    } edge_mode_e;

    // Occupancy needs one bit more than the pointers to tell full from empty.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/edge_capture_stage_sync_chain.sv
// Multi-flop synchroniser for the asynchronous event line.
// All stages reset to 0; q is the last stage.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sr;

    // Shift the raw line through the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/edge_capture_stage.sv
// Edge-triggered data capture into a small FIFO with valid/ready drain.
// Optional EDGE_TIMESTAMP_EN stores a free-running timestamp per entry.
module edge_capture_stage
    import edge_capture_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TS_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    evt_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic [1:0]              mode_i,
    output logic                    out_valid_o,
    output logic [DATA_W-1:0]       out_data_o,
    input  logic                    out_ready_i,
    output logic                    overflow_o,
    input  logic                    clr_ovf_i,
`ifdef EDGE_TIMESTAMP_EN
    output logic [TS_W-1:0]         out_ts_o,
`endif
    output logic [cnt_w(DEPTH)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic              sync;
    logic              prev;
    logic [SYNC_STAGES:0] arm_sr;
    logic              armed;
    edge_mode_e        mode_q;
    logic [DATA_W-1:0] data_r;
    logic              rise;
    logic              fall;
    logic              hit;
    logic              full;
    logic              pop;
    logic              push;
    logic              ovf_set;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (evt_i),
        .q    (sync)
    );

    // Edge history, arming delay, mode register and data aligned to sync.
    // Arming waits until the chain has flushed its reset zeros and prev
    // holds a settled sample, so a line held high over reset is no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev   <= 1'b0;
            arm_sr <= '0;
            mode_q <= EDGE_POS;
            data_r <= '0;
        end else begin
            prev   <= sync;
            arm_sr <= {arm_sr[SYNC_STAGES-1:0], 1'b1};
            mode_q <= edge_mode_e'(mode_i);
            data_r <= data_i;
        end
    end

    assign armed = arm_sr[SYNC_STAGES];

    // Select the edge of interest and derive push/pop/overflow strobes.
    always_comb begin
        rise = sync & ~prev;
        fall = ~sync & prev;
        hit  = 1'b0;
        unique case (mode_q)
            EDGE_POS:  hit = rise;
            EDGE_NEG:  hit = fall;
            EDGE_BOTH: hit = rise | fall;
            EDGE_OFF:  hit = 1'b0;
        endcase
        if (!armed) begin
            hit = 1'b0;
        end
        full    = (count == FULL);
        pop     = (count != '0) & out_ready_i;
        push    = hit & (~full | pop);
        ovf_set = hit & full & ~pop;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_r;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky overflow; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
        end else if (ovf_set) begin
            overflow_o <= 1'b1;
        end else if (clr_ovf_i) begin
            overflow_o <= 1'b0;
        end
    end

`ifdef EDGE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_mem [DEPTH];

    // Free-running timestamp, sampled into the entry written this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ts_mem[i] <= '0;
            end
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (push) begin
                ts_mem[wr_ptr] <= ts_cnt;
            end
        end
    end

    assign out_ts_o = ts_mem[rd_ptr];
`endif

    assign out_valid_o = (count != '0);
    assign out_data_o  = mem[rd_ptr];
    assign count_o     = count;

endmodule
